// File: rtl/phase_accumulator.sv
// Per-operator NCO phase accumulator for the time-multiplexed OPL3 operator
// pipeline. Each accepted slot reads its accumulator (p0), adds the phase
// increment and writes it back (p1), and presents the modulated pre-increment
// phase index (p2). Storage is zeroed one entry per cycle after reset.
module phase_accumulator #(
  parameter int PHASE_ACC_WIDTH = 20,
  parameter int PHASE_OUT_WIDTH = 10,
  parameter int NUM_BANKS       = 2,
  parameter int NUM_OPS         = 18
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       bank_num,
  input  logic [4:0]                 op_num,
  input  logic [PHASE_ACC_WIDTH-1:0] phase_inc,
  input  logic                       restart,
  input  logic [PHASE_OUT_WIDTH-1:0] mod,
  output logic                       busy,
  output logic                       out_valid,
  output logic                       out_bank_num,
  output logic [4:0]                 out_op_num,
  output logic [PHASE_OUT_WIDTH-1:0] phase_out
);

  localparam int NUM_SLOTS = NUM_BANKS * NUM_OPS;
  localparam int IDX_W     = $clog2(NUM_SLOTS);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Control state
  state_t             state_q;
  logic [IDX_W-1:0]   clr_idx_q;
  logic               busy_q;

  // Accumulator storage (one entry per operator slot)
  logic [PHASE_ACC_WIDTH-1:0] acc_mem [NUM_SLOTS];
  logic [PHASE_ACC_WIDTH-1:0] rd_data_q;

  // p1 stage registers
  logic                       p1_valid_q;
  logic [IDX_W-1:0]           p1_idx_q;
  logic                       p1_bank_q;
  logic [4:0]                 p1_op_q;
  logic [PHASE_ACC_WIDTH-1:0] p1_inc_q;
  logic                       p1_restart_q;
  logic [PHASE_OUT_WIDTH-1:0] p1_mod_q;
  logic                       fwd_q;
  logic [PHASE_ACC_WIDTH-1:0] fwd_data_q;

  // p2 / output registers
  logic                       out_valid_q;
  logic                       out_bank_q;
  logic [4:0]                 out_op_q;
  logic [PHASE_OUT_WIDTH-1:0] phase_out_q;

  // Combinational next-state values
  logic                       op_ok_d;
  logic [IDX_W-1:0]           in_idx_d;
  logic [IDX_W-1:0]           rd_addr_d;
  logic                       accept_d;
  logic                       fwd_d;
  logic [PHASE_ACC_WIDTH-1:0] old_acc_d;
  logic [PHASE_ACC_WIDTH-1:0] eff_d;
  logic [PHASE_ACC_WIDTH-1:0] sum_d;
  logic [PHASE_OUT_WIDTH-1:0] phase_d;
  logic                       wr_en_d;
  logic [IDX_W-1:0]           wr_addr_d;
  logic [PHASE_ACC_WIDTH-1:0] wr_data_d;

  // Slot decode, acceptance and same-slot forwarding detection at p0
  always_comb begin
    op_ok_d   = (int'(op_num) < NUM_OPS);
    in_idx_d  = (bank_num ? IDX_W'(NUM_OPS) : '0) + IDX_W'(op_num);
    rd_addr_d = op_ok_d ? in_idx_d : '0;
    accept_d  = in_valid && (state_q == ST_RUN) && op_ok_d;
    // Back-to-back visit to the same slot: storage has not seen the p1
    // write yet, so the p0 read must take the value being written.
    fwd_d     = accept_d && p1_valid_q && (p1_idx_q == in_idx_d);
  end

  // p1 arithmetic: pick the old phase, apply key-on restart, integrate
  always_comb begin
    old_acc_d = fwd_q ? fwd_data_q : rd_data_q;
    eff_d     = p1_restart_q ? '0 : old_acc_d;
    sum_d     = eff_d + p1_inc_q;
    phase_d   = eff_d[PHASE_ACC_WIDTH-1 -: PHASE_OUT_WIDTH] + p1_mod_q;
  end

  // Single write port shared by the clear sweep and the p1 write-back
  always_comb begin
    wr_en_d   = (state_q == ST_CLEAR) || p1_valid_q;
    wr_addr_d = (state_q == ST_CLEAR) ? clr_idx_q : p1_idx_q;
    wr_data_d = (state_q == ST_CLEAR) ? '0 : sum_d;
  end

  // Clear/run controller: one zero write per cycle, then run
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      if (clr_idx_q == IDX_W'(NUM_SLOTS - 1)) begin
        state_q   <= ST_RUN;
        clr_idx_q <= '0;
        busy_q    <= 1'b0;
      end else begin
        clr_idx_q <= clr_idx_q + IDX_W'(1);
      end
    end
  end

  // Accumulator storage write port
  always_ff @(posedge clk) begin
    if (wr_en_d) begin
      acc_mem[wr_addr_d] <= wr_data_d;
    end
  end

  // Accumulator storage registered read port
  always_ff @(posedge clk) begin
    rd_data_q <= acc_mem[rd_addr_d];
  end

  // p0 -> p1 slot registers
  always_ff @(posedge clk) begin
    if (reset) begin
      p1_valid_q <= 1'b0;
      fwd_q      <= 1'b0;
    end else begin
      p1_valid_q <= accept_d;
      fwd_q      <= fwd_d;
    end
    fwd_data_q   <= sum_d;
    p1_idx_q     <= in_idx_d;
    p1_bank_q    <= bank_num;
    p1_op_q      <= op_num;
    p1_inc_q     <= phase_inc;
    p1_restart_q <= restart;
    p1_mod_q     <= mod;
  end

  // p1 -> p2 output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_bank_q  <= 1'b0;
      out_op_q    <= '0;
      phase_out_q <= '0;
    end else begin
      out_valid_q <= p1_valid_q;
      if (p1_valid_q) begin
        out_bank_q  <= p1_bank_q;
        out_op_q    <= p1_op_q;
        phase_out_q <= phase_d;
      end
    end
  end

  assign busy         = busy_q;
  assign out_valid    = out_valid_q;
  assign out_bank_num = out_bank_q;
  assign out_op_num   = out_op_q;
  assign phase_out    = phase_out_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Bench for phase_accumulator: serial reference model with per-cycle output
// comparison, plus directed scenarios with hand-computed expected phases.
module tb_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        bank_num = 1'b0;
  logic [4:0]  op_num = '0;
  logic [19:0] phase_inc = '0;
  logic        restart = 1'b0;
  logic [9:0]  mod = '0;
  logic        busy;
  logic        out_valid;
  logic        out_bank_num;
  logic [4:0]  out_op_num;
  logic [9:0]  phase_out;

  phase_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .bank_num(bank_num),
    .op_num(op_num), .phase_inc(phase_inc), .restart(restart), .mod(mod),
    .busy(busy), .out_valid(out_valid), .out_bank_num(out_bank_num),
    .out_op_num(out_op_num), .phase_out(phase_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic       bank;
    logic [4:0] op;
    logic [9:0] ph;
  } exp_t;

  exp_t        eq[$];
  logic [9:0]  obs[$];
  int          m_acc [36];
  int          m_busy = 0;
  int          ecount = 0;
  bit          m_init = 0;
  bit          m_rst_edge = 0;
  int          errors = 0;
  int          checks = 0;
  int          m_idx;
  int          m_old;
  exp_t        m_e;

  // Reference model: serial semantics, one slot at a time in issue order
  always @(posedge clk) begin
    ecount++;
    m_rst_edge = 0;
    if (reset) begin
      m_init = 1;
      m_rst_edge = 1;
      m_busy = 36;
      eq.delete();
      for (int i = 0; i < 36; i++) m_acc[i] = 0;
    end else begin
      if (m_busy == 0 && in_valid && int'(op_num) < 18) begin
        m_idx = int'(bank_num) * 18 + int'(op_num);
        m_old = restart ? 0 : m_acc[m_idx];
        m_e.due  = ecount + 1;
        m_e.bank = bank_num;
        m_e.op   = op_num;
        m_e.ph   = 10'((m_old / 1024 + int'(mod)) % 1024);
        eq.push_back(m_e);
        m_acc[m_idx] = (m_old + int'(phase_inc)) % (1 << 20);
      end
      if (m_busy > 0) m_busy--;
    end
  end

  // Per-cycle compare of DUT outputs against the model
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (out_valid === 1'b1) obs.push_back(phase_out);
    if (m_init) begin
      checks++;
      if (busy !== (m_busy > 0)) begin
        errors++;
        $display("FAIL busy @%0d: got %b expected %b", ecount, busy, m_busy > 0);
      end
      if (m_rst_edge) begin
        checks++;
        if (phase_out !== 10'd0 || out_bank_num !== 1'b0 || out_op_num !== 5'd0) begin
          errors++;
          $display("FAIL reset_outputs @%0d: got ph=%h bank=%b op=%0d expected 0/0/0",
                   ecount, phase_out, out_bank_num, out_op_num);
        end
      end
      if (eq.size() > 0 && eq[0].due == ecount) begin
        e = eq.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_bank_num !== e.bank || out_op_num !== e.op || phase_out !== e.ph) begin
          errors++;
          $display("FAIL output @%0d: got v=%b bank=%b op=%0d ph=%h expected v=1 bank=%b op=%0d ph=%h",
                   ecount, out_valid, out_bank_num, out_op_num, phase_out, e.bank, e.op, e.ph);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL spurious_valid @%0d: got out_valid=%b expected 0", ecount, out_valid);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_obs(input string name, input int n, input int e0, input int e1,
                         input int e2, input int e3);
    int ev;
    chk({name, "_count"}, obs.size(), n);
    for (int i = 0; i < n && i < obs.size(); i++) begin
      ev = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
      chk($sformatf("%s[%0d]", name, i), int'(obs[i]), ev);
    end
  endtask

  task automatic slot(input logic b, input int o, input int inc, input logic rs, input int m);
    in_valid  = 1'b1;
    bank_num  = b;
    op_num    = 5'(o);
    phase_inc = 20'(inc);
    restart   = rs;
    mod       = 10'(m);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    restart  = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_clear();
    for (int i = 0; i < 100 && m_busy > 0; i++) @(negedge clk);
    chk("clear_done_busy", int'(busy), 0);
  endtask

  task automatic sweep_all(input bit zero_mod);
    int mv;
    obs.delete();
    for (int i = 0; i < 36; i++) begin
      mv = zero_mod ? 0 : (i * 29 + 3) % 1024;
      slot(i >= 18, i % 18, 0, 1'b0, mv);
    end
    idle(4);
    chk("sweep_count", obs.size(), 36);
    for (int i = 0; i < 36 && i < obs.size(); i++) begin
      mv = zero_mod ? 0 : (i * 29 + 3) % 1024;
      chk($sformatf("sweep[%0d]", i), int'(obs[i]), mv);
    end
  endtask

  initial begin
    int busy_cycles;
    @(negedge clk);
    do_reset();

    // Clear sweep with in_valid held high: inputs must be ignored
    busy_cycles = 0;
    for (int i = 0; i < 36; i++) begin
      busy_cycles += int'(busy === 1'b1);
      slot(1'b0, 3, 'h12345, 1'b0, 5);
    end
    for (int i = 0; i < 4; i++) begin
      busy_cycles += int'(busy === 1'b1);
      idle(1);
    end
    chk("busy_cycles", busy_cycles, 36);
    sweep_all(1'b0);

    // Spaced visits: 0x1000 per visit -> index steps of 4
    obs.delete();
    for (int v = 0; v < 4; v++) begin
      slot(1'b0, 3, 'h01000, 1'b0, 0);
      idle(4);
    end
    chk_obs("spaced", 4, 0, 4, 8, 12);

    // Accumulator and output-sum wraparound
    obs.delete();
    for (int v = 0; v < 3; v++) begin
      slot(1'b0, 5, 'hFFC00, 1'b0, 'h3FF);
      idle(3);
    end
    chk_obs("wrap", 3, 'h3FF, 'h3FE, 'h3FD, 0);

    // Back-to-back same slot exercises the forwarding path
    obs.delete();
    slot(1'b1, 17, 'h400, 1'b0, 0);
    slot(1'b1, 17, 'h400, 1'b0, 0);
    slot(1'b1, 17, 'h400, 1'b0, 0);
    idle(3);
    slot(1'b1, 17, 'h400, 1'b0, 0);
    idle(4);
    chk_obs("b2b", 4, 0, 1, 2, 3);

    // Restart on the middle of three back-to-back visits; last visit reads 0x800
    obs.delete();
    slot(1'b1, 16, 'h400, 1'b0, 0);
    slot(1'b1, 16, 'h400, 1'b1, 0);
    slot(1'b1, 16, 'h400, 1'b0, 0);
    idle(3);
    slot(1'b1, 16, 0, 1'b0, 0);
    idle(4);
    chk_obs("restart", 4, 0, 0, 1, 2);

    // Out-of-range op numbers interleaved with a real slot
    obs.delete();
    slot(1'b0, 3, 0, 1'b0, 0);
    slot(1'b0, 20, 'h55555, 1'b0, 7);
    slot(1'b1, 31, 'h55555, 1'b1, 9);
    slot(1'b0, 3, 0, 1'b0, 0);
    idle(4);
    chk_obs("oob", 2, 16, 16, 0, 0);

    // Reset mid-clear, then reset with slots in flight
    idle(1);
    do_reset();
    idle(10);
    chk("midclear_busy", int'(busy), 1);
    do_reset();
    wait_clear();
    obs.delete();
    slot(1'b0, 7, 'h11111, 1'b0, 3);
    slot(1'b0, 8, 'h22222, 1'b0, 4);
    in_valid = 1'b0;
    do_reset();
    idle(3);
    chk("inflight_outputs", obs.size(), 1);
    wait_clear();
    sweep_all(1'b1);

    idle(4);
    chk("queue_drained", eq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
